// File: rtl/serial_subtract_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic controllers: FSM state encodings
// and the legal operand-width range.
package serial_subtract_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/serial_subtract_ctrl_bit_sub_cell.sv
// Combinational 1-bit full subtractor: x - y - bin -> {bout, d}.
module bit_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: one full-subtractor cell stepped LSB first,
// start/busy/done handshake, registered diff/bout/zero held until the next result.
module serial_subtract_ctrl
    import serial_subtract_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_subtract_ctrl: WIDTH out of range");
    end

    ser_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_r;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_br;
    logic [WIDTH-1:0] res_next;

    bit_sub_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow_r),
        .d    (cell_d),
        .bout (cell_br)
    );

    // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
    assign res_next = {cell_d, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            zero     <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_r <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_r <= 1'b0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    res_sr   <= res_next;
                    borrow_r <= cell_br;
                    cnt      <= cnt + 1'b1;
                    // Last bit: publish the result straight from the cell outputs.
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_next;
                        bout  <= cell_br;
                        zero  <= (res_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Scoreboard bench for serial_subtract_ctrl: directed WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtract_ctrl;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       busy8, done8, bout8, zero8;
    logic [7:0] diff8;
    logic       busy4, done4, bout4, zero4;
    logic [3:0] diff4;

    exp_t q8[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt8 = 0;

    always #5 clk = ~clk;

    serial_subtract_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
    );

    serial_subtract_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop an expected result on every done pulse.
    always @(negedge clk) begin
        if (!rst && done8) begin
            exp_t e;
            done_cnt8++;
            if (q8.size() == 0) begin
                chk("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("diff8", {24'd0, diff8}, {24'd0, e.diff});
                chk("bout8", {31'd0, bout8}, {31'd0, e.bout});
                chk("zero8", {31'd0, zero8}, {31'd0, e.zero});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            exp_t e;
            if (q4.size() == 0) begin
                chk("unexpected_done4", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                chk("diff4", {28'd0, diff4}, {24'd0, e.diff});
                chk("bout4", {31'd0, bout4}, {31'd0, e.bout});
                chk("zero4", {31'd0, zero4}, {31'd0, e.zero});
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic ez);
        int n;
        q8.push_back('{diff: ed, bout: eb, zero: ez});
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency8", n, 9);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b);
        int n;
        logic [3:0] d;
        d = a - b;
        q4.push_back('{diff: {4'd0, d}, bout: (a < b), zero: (d == 4'd0)});
        a4 = a; b4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("latency4", n, 5);
    endtask

    initial begin
        int dc;
        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_flags", {30'd0, bout8, zero8}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        run8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_hold_diff", {24'd0, diff8}, 32'h37);
        chk("idle_busy", {31'd0, busy8}, 32'd0);
        run8(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run8(8'h7F, 8'h7F, 8'h00, 1'b0, 1'b1);
        @(negedge clk);

        // start while busy must be ignored
        dc = done_cnt8;
        q8.push_back('{diff: 8'h04, bout: 1'b0, zero: 1'b0});
        a8 = 8'h05; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_mid", {31'd0, busy8}, 32'd1);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (20) @(negedge clk);
        chk("one_done_pulse", done_cnt8 - dc, 1);

        // Reset in the 4th SHIFT cycle aborts
        q8.push_back('{diff: 8'h55, bout: 1'b0, zero: 1'b0});
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q8.delete();
        dc = done_cnt8;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_diff", {24'd0, diff8}, 32'd0);
        chk("abort_flags", {30'd0, bout8, zero8}, 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_cnt8 - dc, 0);

        // Continuous start: back-to-back with no bubble
        dc = done_cnt8;
        repeat (3) q8.push_back('{diff: 8'h06, bout: 1'b0, zero: 1'b0});
        a8 = 8'h09; b8 = 8'h03; start8 = 1'b1;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            chk("b2b_done_slot", {31'd0, done8}, {31'd0, (i % 9) == 0});
            chk("b2b_busy", {31'd0, busy8}, {31'd0, (i % 9) != 0});
        end
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_done_count", done_cnt8 - dc, 3);

        // Exhaustive WIDTH=4 sweep against the arithmetic model
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run4(4'(i), 4'(j));

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
